// File: rtl/ysyx_23060251_ifu.sv
// Instruction fetch stage: owns the PC, keeps one imem read outstanding, hands {pc, inst} to decode.
// Optional YSYX_23060251_IFU_ALIGN_CHK_EN: misaligned fetch PCs fault locally without an AR beat.
module ysyx_23060251_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] araddr_o,
    output logic            arvalid_o,
    input  logic            arready_i,
    input  logic [31:0]     rdata_i,
    input  logic [1:0]      rresp_i,
    input  logic            rvalid_i,
    output logic            rready_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o,
    output logic            valid_o,
    input  logic            ready_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

`ifdef YSYX_23060251_IFU_ALIGN_CHK_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
`endif

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] araddr_n, pc_out_n;
    logic            arvalid_n, rready_n, valid_n, fault_n;
    logic [31:0]     inst_n;
    logic            launch;
    logic [XLEN-1:0] launch_addr;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            araddr_o  <= RESET_PC;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b0;
            valid_o   <= 1'b0;
            fault_o   <= 1'b0;
            inst_o    <= 32'h0;
            pc_o      <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            araddr_o  <= araddr_n;
            arvalid_o <= arvalid_n;
            rready_o  <= rready_n;
            valid_o   <= valid_n;
            fault_o   <= fault_n;
            inst_o    <= inst_n;
            pc_o      <= pc_out_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        araddr_n    = araddr_o;
        arvalid_n   = arvalid_o;
        rready_n    = rready_o;
        valid_n     = valid_o;
        fault_n     = fault_o;
        inst_n      = inst_o;
        pc_out_n    = pc_o;
        launch      = 1'b0;
        launch_addr = pc;

        case (state)
            IDLE: begin
                launch = 1'b1;
                if (redirect_valid_i) begin
                    pc_n        = redirect_pc_i;
                    launch_addr = redirect_pc_i;
                end
            end
            REQ: begin
                // The AR beat in flight cannot be withdrawn; mark its response for discard.
                if (redirect_valid_i) begin
                    pc_n   = redirect_pc_i;
                    drop_n = 1'b1;
                end
                if (arready_i) begin
                    state_n   = WAIT;
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end
            end
            WAIT: begin
                if (rvalid_i) begin
                    rready_n = 1'b0;
                    if (redirect_valid_i) begin
                        pc_n        = redirect_pc_i;
                        drop_n      = 1'b0;
                        launch      = 1'b1;
                        launch_addr = redirect_pc_i;
                    end else if (drop) begin
                        drop_n = 1'b0;
                        launch = 1'b1;
                    end else begin
                        inst_n   = rdata_i;
                        pc_out_n = pc;
                        fault_n  = (rresp_i != 2'b00);
                        valid_n  = 1'b1;
                        state_n  = HOLD;
                    end
                end else if (redirect_valid_i) begin
                    pc_n   = redirect_pc_i;
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                // A same-cycle handshake still counts, but the redirect target wins over pc+4.
                if (redirect_valid_i) begin
                    valid_n     = 1'b0;
                    pc_n        = redirect_pc_i;
                    launch      = 1'b1;
                    launch_addr = redirect_pc_i;
                end else if (ready_i) begin
                    valid_n     = 1'b0;
                    pc_n        = pc + XLEN'(4);
                    launch      = 1'b1;
                    launch_addr = pc + XLEN'(4);
                end
            end
            default: state_n = IDLE;
        endcase

        if (launch) begin
            state_n   = REQ;
            araddr_n  = launch_addr;
            arvalid_n = 1'b1;
`ifdef YSYX_23060251_IFU_ALIGN_CHK_EN
            if (launch_addr[1:0] != 2'b00) begin
                state_n   = HOLD;
                araddr_n  = araddr_o;
                arvalid_n = 1'b0;
                valid_n   = 1'b1;
                fault_n   = 1'b1;
                inst_n    = NOP;
                pc_out_n  = launch_addr;
            end
`endif
        end
    end

endmodule
